// File: rtl/io_out_pkg.sv
// Shared constants and types for the LSU output peripheral.
package io_out_pkg;

    // Window match on addr[15:10] and register offsets on addr[7:0].
    localparam logic [5:0] IoWindow   = 6'b011100;
    localparam logic [7:0] OffLedr    = 8'h00;
    localparam logic [7:0] OffLedg    = 8'h10;
    localparam logic [7:0] OffHexLo   = 8'h20;
    localparam logic [7:0] OffHexHi   = 8'h24;
    localparam logic [7:0] OffLcd     = 8'h30;
    localparam logic [7:0] OffLcdStat = 8'h34;
    localparam logic [7:0] OffMask    = 8'h40;
    localparam logic [7:0] OffPeriod  = 8'h44;

    // Alias operation selected by addr[9:8].
    typedef enum logic [1:0] {
        OpWr  = 2'b00,
        OpSet = 2'b01,
        OpClr = 2'b10,
        OpTgl = 2'b11
    } alias_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } lcd_state_e;

    // Field positions in the LCD word.
    localparam int unsigned LcdOnBit = 31;
    localparam int unsigned LcdEnBit = 10;
    localparam int unsigned LcdRsBit = 9;
    localparam int unsigned LcdRwBit = 8;

    // Apply the alias operation, then keep only the enabled bytes.
    function automatic logic [31:0] merge_word(input alias_op_e  op,
                                               input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  bmask);
        logic [31:0] upd;
        logic [31:0] res;
        case (op)
            OpWr:    upd = wdata;
            OpSet:   upd = old | wdata;
            OpClr:   upd = old & ~wdata;
            default: upd = old ^ wdata;
        endcase
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = bmask[k] ? upd[8*k +: 8] : old[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lcd_strobe_seq.sv
// LCD enable-strobe sequencer: setup, EN pulse, hold; tracks busy and sticky overrun.
module lcd_strobe_seq
    import io_out_pkg::*;
#(
    parameter int unsigned LCD_SETUP_CYC = 2,
    parameter int unsigned LCD_E_CYC     = 12,
    parameter int unsigned LCD_HOLD_CYC  = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic wr_i,
    input  logic clr_ovr_i,
    output logic accept_o,
    output logic busy_o,
    output logic en_o,
    output logic ovr_o
);

    localparam int unsigned MaxCyc0 = (LCD_SETUP_CYC > LCD_E_CYC) ? LCD_SETUP_CYC : LCD_E_CYC;
    localparam int unsigned MaxCyc  = (MaxCyc0 > LCD_HOLD_CYC) ? MaxCyc0 : LCD_HOLD_CYC;
    localparam int unsigned CntW    = ($clog2(MaxCyc) < 1) ? 1 : $clog2(MaxCyc);

    localparam logic [CntW-1:0] SetupLast = CntW'(LCD_SETUP_CYC - 1);
    localparam logic [CntW-1:0] StrobeLast = CntW'(LCD_E_CYC - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(LCD_HOLD_CYC - 1);

    lcd_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovr_q, ovr_d;

    // State, phase counter and overrun flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next state: each phase lasts its parameter count of cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        accept_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_i) begin
                    accept_o = 1'b1;
                    state_d  = StSetup;
                    cnt_d    = '0;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    state_d = StStrobe;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStrobe: begin
                if (cnt_q == StrobeLast) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // A dropped write outranks a same-cycle clear.
        if (wr_i && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end else if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign en_o   = (state_q == StStrobe);
    assign ovr_o  = ovr_q;

endmodule

// File: rtl/io_out_periph.sv
// Memory-mapped output peripheral: LED/HEX/LCD registers, aliases, blink and LCD strobe.
module io_out_periph
    import io_out_pkg::*;
#(
    parameter int unsigned LEDR_W        = 32,
    parameter int unsigned LEDG_W        = 32,
    parameter int unsigned PRESC_W       = 24,
    parameter int unsigned LCD_SETUP_CYC = 2,
    parameter int unsigned LCD_E_CYC     = 12,
    parameter int unsigned LCD_HOLD_CYC  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_lsu_wren,
    input  logic [3:0]  i_lsu_bmask,
    input  logic [15:0] i_op_addr,
    input  logic [31:0] i_op_data,
    output logic [31:0] o_op_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd
);

    localparam logic [63:0] LedrMask64 = (64'd1 << LEDR_W) - 64'd1;
    localparam logic [63:0] LedgMask64 = (64'd1 << LEDG_W) - 64'd1;
    localparam logic [31:0] LedrMask   = LedrMask64[31:0];
    localparam logic [31:0] LedgMask   = LedgMask64[31:0];

    logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d;
    logic [31:0] hex_lo_q, hex_lo_d, hex_hi_q, hex_hi_d;
    logic [31:0] mask_q, mask_d, period_q, period_d;
    logic        lcd_on_q, lcd_on_d, lcd_rs_q, lcd_rs_d, lcd_rw_q, lcd_rw_d;
    logic [7:0]  lcd_data_q, lcd_data_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic        phase_q, phase_d;

    logic        hit, wr, plain;
    alias_op_e   op;
    logic [7:0]  off;
    logic        lcd_wr, stat_clr, period_wr;
    logic        lcd_accept, lcd_busy, lcd_en, lcd_ovr;
    logic [31:0] lcd_word;

    assign hit       = (i_op_addr[15:10] == IoWindow);
    assign op        = alias_op_e'(i_op_addr[9:8]);
    assign off       = i_op_addr[7:0];
    assign wr        = i_lsu_wren & hit;
    assign plain     = (op == OpWr);
    assign lcd_wr    = wr & plain & (off == OffLcd);
    assign stat_clr  = wr & plain & (off == OffLcdStat) & i_lsu_bmask[0] & i_op_data[1];
    assign period_wr = wr & plain & (off == OffPeriod);

    lcd_strobe_seq #(
        .LCD_SETUP_CYC(LCD_SETUP_CYC),
        .LCD_E_CYC    (LCD_E_CYC),
        .LCD_HOLD_CYC (LCD_HOLD_CYC)
    ) u_lcd_seq (
        .clk_i    (i_clk),
        .rst_ni   (i_rst),
        .wr_i     (lcd_wr),
        .clr_ovr_i(stat_clr),
        .accept_o (lcd_accept),
        .busy_o   (lcd_busy),
        .en_o     (lcd_en),
        .ovr_o    (lcd_ovr)
    );

    // Register file, LCD latch and blink prescaler state.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ledr_q     <= '0;
            ledg_q     <= '0;
            hex_lo_q   <= '0;
            hex_hi_q   <= '0;
            mask_q     <= '0;
            period_q   <= '0;
            lcd_on_q   <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_rw_q   <= 1'b0;
            lcd_data_q <= '0;
            presc_q    <= '0;
            phase_q    <= 1'b0;
        end else begin
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            hex_lo_q   <= hex_lo_d;
            hex_hi_q   <= hex_hi_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            lcd_on_q   <= lcd_on_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_rw_q   <= lcd_rw_d;
            lcd_data_q <= lcd_data_d;
            presc_q    <= presc_d;
            phase_q    <= phase_d;
        end
    end

    // Store decode with alias/byte-enable merge; LCD fields latch only on accept.
    always_comb begin
        ledr_d     = ledr_q;
        ledg_d     = ledg_q;
        hex_lo_d   = hex_lo_q;
        hex_hi_d   = hex_hi_q;
        mask_d     = mask_q;
        period_d   = period_q;
        lcd_on_d   = lcd_on_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_rw_d   = lcd_rw_q;
        lcd_data_d = lcd_data_q;
        if (wr) begin
            case (off)
                OffLedr:   ledr_d = merge_word(op, ledr_q, i_op_data, i_lsu_bmask) & LedrMask;
                OffLedg:   ledg_d = merge_word(op, ledg_q, i_op_data, i_lsu_bmask) & LedgMask;
                OffHexLo:  hex_lo_d = merge_word(op, hex_lo_q, i_op_data, i_lsu_bmask);
                OffHexHi:  hex_hi_d = merge_word(op, hex_hi_q, i_op_data, i_lsu_bmask);
                OffMask:   mask_d = merge_word(op, mask_q, i_op_data, i_lsu_bmask);
                OffPeriod: begin
                    if (plain) period_d = merge_word(OpWr, period_q, i_op_data, i_lsu_bmask);
                end
                default: ;
            endcase
        end
        if (lcd_accept) begin
            if (i_lsu_bmask[3]) lcd_on_d = i_op_data[LcdOnBit];
            if (i_lsu_bmask[1]) lcd_rs_d = i_op_data[LcdRsBit];
            if (i_lsu_bmask[1]) lcd_rw_d = i_op_data[LcdRwBit];
            if (i_lsu_bmask[0]) lcd_data_d = i_op_data[7:0];
        end
    end

    // Blink prescaler: 0..PERIOD then toggle phase; period write restarts it.
    always_comb begin
        presc_d = presc_q;
        phase_d = phase_q;
        if (period_wr || (period_q[PRESC_W-1:0] == '0)) begin
            presc_d = '0;
            phase_d = 1'b0;
        end else if (presc_q == period_q[PRESC_W-1:0]) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    assign lcd_word = {lcd_on_q, 20'b0, lcd_en, lcd_rs_q, lcd_rw_q, lcd_data_q};

    // Load path: alias bits are don't-care, anything outside the window reads 0.
    always_comb begin
        o_op_data = '0;
        if (hit) begin
            case (off)
                OffLedr:    o_op_data = ledr_q;
                OffLedg:    o_op_data = ledg_q;
                OffHexLo:   o_op_data = hex_lo_q;
                OffHexHi:   o_op_data = hex_hi_q;
                OffLcd:     o_op_data = lcd_word;
                OffLcdStat: o_op_data = {30'b0, lcd_ovr, lcd_busy};
                OffMask:    o_op_data = mask_q;
                OffPeriod:  o_op_data = period_q;
                default:    o_op_data = '0;
            endcase
        end
    end

    assign o_io_ledr = ledr_q & ~(mask_q & {32{phase_q}});
    assign o_io_ledg = ledg_q;
    assign o_io_hex0 = hex_lo_q[6:0];
    assign o_io_hex1 = hex_lo_q[14:8];
    assign o_io_hex2 = hex_lo_q[22:16];
    assign o_io_hex3 = hex_lo_q[30:24];
    assign o_io_hex4 = hex_hi_q[6:0];
    assign o_io_hex5 = hex_hi_q[14:8];
    assign o_io_hex6 = hex_hi_q[22:16];
    assign o_io_hex7 = hex_hi_q[30:24];
    assign o_io_lcd  = lcd_word;

endmodule

// File: tb/tb_io_out_periph.sv
// Self-checking bench for io_out_periph: vector table, directed LCD/blink sequences, random vs model.
module tb_io_out_periph;

    localparam int S = 2, E = 12, H = 2, TOT = 16;

    logic        clk = 1'b0;
    logic        rst, wren;
    logic [3:0]  bmask;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata, ledr, ledg, lcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    io_out_periph dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_lsu_wren (wren),
        .i_lsu_bmask(bmask),
        .i_op_addr  (addr),
        .i_op_data  (wdata),
        .o_op_data  (rdata),
        .o_io_ledr  (ledr),
        .o_io_ledg  (ledg),
        .o_io_hex0  (hex0),
        .o_io_hex1  (hex1),
        .o_io_hex2  (hex2),
        .o_io_hex3  (hex3),
        .o_io_hex4  (hex4),
        .o_io_hex5  (hex5),
        .o_io_hex6  (hex6),
        .o_io_hex7  (hex7),
        .o_io_lcd   (lcd)
    );

    // Reference model: register contents, LCD age since accept, blink cycles since restart.
    logic [31:0] m_ledr, m_ledg, m_hlo, m_hhi, m_mask, m_per;
    logic        m_on, m_rs, m_rw, m_ovr;
    logic [7:0]  m_dat;
    int          m_age;
    int unsigned m_k;

    function automatic logic [31:0] mmerge(input logic [1:0] op, input logic [31:0] old,
                                           input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        logic [7:0]  o, w;
        r = old;
        for (int b = 0; b < 4; b++) begin
            o = old[8*b +: 8];
            w = wd[8*b +: 8];
            if (be[b]) begin
                case (op)
                    2'd0:    r[8*b +: 8] = w;
                    2'd1:    r[8*b +: 8] = o | w;
                    2'd2:    r[8*b +: 8] = o & ~w;
                    default: r[8*b +: 8] = o ^ w;
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic m_en();
        return (m_age >= S) && (m_age < S + E);
    endfunction

    function automatic logic m_phase();
        int unsigned p;
        p = int'(m_per[23:0]);
        if (p == 0) return 1'b0;
        return ((m_k / (p + 1)) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_lcd();
        return {m_on, 20'b0, m_en(), m_rs, m_rw, m_dat};
    endfunction

    function automatic logic [31:0] mread(input logic [15:0] a);
        if (a[15:10] != 6'b011100) return 32'h0;
        case (a[7:0])
            8'h00:   return m_ledr;
            8'h10:   return m_ledg;
            8'h20:   return m_hlo;
            8'h24:   return m_hhi;
            8'h30:   return m_lcd();
            8'h34:   return {30'b0, m_ovr, m_age < TOT};
            8'h40:   return m_mask;
            8'h44:   return m_per;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic        hit, busy, per_wr, new_ovr;
        logic [1:0]  op;
        logic [7:0]  off;
        logic [31:0] w;
        int          new_age;
        if (!rst) begin
            {m_ledr, m_ledg, m_hlo, m_hhi, m_mask, m_per} = '0;
            {m_on, m_rs, m_rw, m_ovr} = '0;
            m_dat = '0;
            m_age = TOT;
            m_k   = 0;
        end else begin
            hit     = (addr[15:10] == 6'b011100);
            op      = addr[9:8];
            off     = addr[7:0];
            busy    = m_age < TOT;
            new_age = busy ? m_age + 1 : m_age;
            new_ovr = m_ovr;
            per_wr  = 1'b0;
            if (wren && hit) begin
                case (off)
                    8'h00: m_ledr = mmerge(op, m_ledr, wdata, bmask);
                    8'h10: m_ledg = mmerge(op, m_ledg, wdata, bmask);
                    8'h20: m_hlo  = mmerge(op, m_hlo, wdata, bmask);
                    8'h24: m_hhi  = mmerge(op, m_hhi, wdata, bmask);
                    8'h40: m_mask = mmerge(op, m_mask, wdata, bmask);
                    8'h44: if (op == 2'd0) begin
                        m_per  = mmerge(2'd0, m_per, wdata, bmask);
                        per_wr = 1'b1;
                    end
                    8'h30: if (op == 2'd0) begin
                        if (busy) begin
                            new_ovr = 1'b1;
                        end else begin
                            w = mmerge(2'd0, {m_on, 20'b0, 1'b0, m_rs, m_rw, m_dat}, wdata, bmask);
                            {m_on, m_rs, m_rw, m_dat} = {w[31], w[9], w[8], w[7:0]};
                            new_age = 0;
                        end
                    end
                    8'h34: if (op == 2'd0 && bmask[0] && wdata[1]) new_ovr = 1'b0;
                    default: ;
                endcase
            end
            m_k   = per_wr ? 0 : m_k + 1;
            m_age = new_age;
            m_ovr = new_ovr;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs();
        chk("ledr", ledr, m_ledr & ~(m_mask & {32{m_phase()}}));
        chk("ledg", ledg, m_ledg);
        chk("hex0", 32'(hex0), 32'(m_hlo[6:0]));
        chk("hex1", 32'(hex1), 32'(m_hlo[14:8]));
        chk("hex2", 32'(hex2), 32'(m_hlo[22:16]));
        chk("hex3", 32'(hex3), 32'(m_hlo[30:24]));
        chk("hex4", 32'(hex4), 32'(m_hhi[6:0]));
        chk("hex5", 32'(hex5), 32'(m_hhi[14:8]));
        chk("hex6", 32'(hex6), 32'(m_hhi[22:16]));
        chk("hex7", 32'(hex7), 32'(m_hhi[30:24]));
        chk("lcd", lcd, m_lcd());
    endtask

    task automatic cyc(input logic r, input logic w, input logic [3:0] be,
                       input logic [15:0] a, input logic [31:0] d);
        rst   = r;
        wren  = w;
        bmask = be;
        addr  = a;
        wdata = d;
        model_step();
        @(posedge clk);
        #1;
        wren = 1'b0;
        check_outs();
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 4'h0, 16'h0, 32'h0);
    endtask

    task automatic rchk(input string name, input logic [15:0] a, input logic [31:0] exp);
        addr = a;
        wren = 1'b0;
        #1;
        chk(name, rdata, exp);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [15:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[14];

    logic [7:0] offs[10];

    initial begin
        vt[0]  = '{16'h7000, 32'hAABBCCDD, 4'b0101, 16'h7000, 32'h00BB00DD};
        vt[1]  = '{16'h7010, 32'h0000F0F0, 4'b1111, 16'h7010, 32'h0000F0F0};
        vt[2]  = '{16'h7110, 32'h0000000F, 4'b1111, 16'h7010, 32'h0000F0FF};
        vt[3]  = '{16'h7210, 32'h000000F0, 4'b1111, 16'h7210, 32'h0000F00F};
        vt[4]  = '{16'h7310, 32'h0000FFFF, 4'b1111, 16'h7010, 32'h00000FF0};
        vt[5]  = '{16'h7020, 32'h87654321, 4'b1111, 16'h7020, 32'h87654321};
        vt[6]  = '{16'h7024, 32'h0000807F, 4'b0011, 16'h7324, 32'h0000807F};
        vt[7]  = '{16'h7124, 32'h00000100, 4'b0010, 16'h7024, 32'h0000817F};
        vt[8]  = '{16'h7050, 32'hFFFFFFFF, 4'b1111, 16'h7050, 32'h00000000};
        vt[9]  = '{16'h6000, 32'hFFFFFFFF, 4'b1111, 16'h7000, 32'h00BB00DD};
        vt[10] = '{16'h7144, 32'h00000005, 4'b1111, 16'h7044, 32'h00000000};
        vt[11] = '{16'h7040, 32'h0000000F, 4'b0001, 16'h7040, 32'h0000000F};
        vt[12] = '{16'h7234, 32'h00000002, 4'b1111, 16'h7034, 32'h00000000};
        vt[13] = '{16'h7000, 32'h00000000, 4'b0000, 16'h7000, 32'h00BB00DD};
        offs = '{8'h00, 8'h10, 8'h20, 8'h24, 8'h30, 8'h34, 8'h40, 8'h44, 8'h50, 8'h04};

        rst = 1'b0; wren = 1'b0; bmask = '0; addr = '0; wdata = '0;
        m_age = TOT; m_k = 0;

        // Reset state.
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        chk("rst_ledr", ledr, 32'h0);
        chk("rst_lcd", lcd, 32'h0);
        rchk("rst_stat", 16'h7034, 32'h0);
        idle();

        // Vector table: write, then read back through the load path.
        foreach (vt[i]) begin
            cyc(1'b1, 1'b1, vt[i].be, vt[i].a, vt[i].d);
            rchk($sformatf("vec%0d", i), vt[i].ra, vt[i].exp);
        end
        chk("hex3_bit7_hidden", 32'(hex3), 32'h07);
        chk("hex5_set", 32'(hex5), 32'h01);
        chk("ledr_bytes", ledr, 32'h00BB00DD);

        // Blink: LEDR=FF, MASK=0F, PERIOD=3 -> 4 cycles FF, 4 cycles F0.
        cyc(1'b1, 1'b1, 4'hF, 16'h7000, 32'h000000FF);
        cyc(1'b1, 1'b1, 4'hF, 16'h7044, 32'h00000003);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) idle();
            chk("blink", ledr, ((k / 4) % 2 == 1) ? 32'hF0 : 32'hFF);
        end
        cyc(1'b1, 1'b1, 4'hF, 16'h7044, 32'h00000000);
        for (int k = 0; k < 8; k++) begin
            idle();
            chk("blink_off", ledr, 32'hFF);
        end

        // LCD strobe timing relative to the accept edge.
        cyc(1'b1, 1'b1, 4'hF, 16'h7030, 32'h80000241);
        for (int a = 0; a < 18; a++) begin
            if (a > 0) idle();
            chk("lcd_en", 32'(lcd[10]), 32'((a >= 2) && (a < 14)));
            chk("lcd_low", 32'(lcd[9:0]), 32'h241);
            chk("lcd_on", 32'(lcd[31]), 32'h1);
            rchk("lcd_busy", 16'h7034, (a < 16) ? 32'h1 : 32'h0);
        end

        // Overrun: second write while busy is dropped, ovr sticks, write 0x2 clears.
        cyc(1'b1, 1'b1, 4'hF, 16'h7030, 32'h00000155);
        for (int a = 1; a < 4; a++) idle();
        cyc(1'b1, 1'b1, 4'hF, 16'h7030, 32'h80000322);
        rchk("ovr_busy", 16'h7034, 32'h3);
        chk("ovr_kept", 32'(lcd[7:0]), 32'h55);
        for (int a = 5; a <= 16; a++) idle();
        rchk("ovr_done", 16'h7034, 32'h2);
        cyc(1'b1, 1'b1, 4'h1, 16'h7034, 32'h00000002);
        rchk("ovr_clr", 16'h7034, 32'h0);

        // Write on the final HOLD edge is still dropped.
        cyc(1'b1, 1'b1, 4'hF, 16'h7030, 32'h00000011);
        for (int a = 1; a < 16; a++) idle();
        cyc(1'b1, 1'b1, 4'hF, 16'h7030, 32'h00000022);
        rchk("ovr_final_edge", 16'h7034, 32'h2);
        chk("final_edge_data", 32'(lcd[7:0]), 32'h11);
        cyc(1'b1, 1'b1, 4'h1, 16'h7034, 32'h00000002);

        // Reset mid-strobe.
        cyc(1'b1, 1'b1, 4'hF, 16'h7030, 32'h80000241);
        for (int a = 1; a <= 4; a++) idle();
        chk("pre_rst_en", 32'(lcd[10]), 32'h1);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        chk("rst_mid_lcd", lcd, 32'h0);
        chk("rst_mid_ledr", ledr, 32'h0);
        chk("rst_mid_ledg", ledg, 32'h0);
        rchk("rst_mid_stat", 16'h7034, 32'h0);
        idle();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] a, ra;
            logic [31:0] d;
            logic [7:0]  o;
            o = offs[$urandom_range(0, 9)];
            a = {6'b011100, 2'($urandom_range(0, 3)), o};
            if ($urandom_range(0, 15) == 0) a[15:10] = 6'($urandom);
            d = $urandom;
            if (o == 8'h44) d = 32'($urandom_range(0, 6));
            cyc(($urandom_range(0, 99) != 0), 1'($urandom), 4'($urandom), a, d);
            ra = {6'b011100, 2'($urandom_range(0, 3)), offs[$urandom_range(0, 9)]};
            rchk("rand_rd", ra, mread(ra));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
